// File: rtl/dmem_responder.sv
// dmem_responder: byte-lane data memory slave with a fixed number of wait
// states per access. Four byte lanes back DEPTH_WORDS 32-bit words; loads
// return the addressed lanes right-justified, stores update only the
// addressed lanes. Misaligned, out-of-range and illegal-mode accesses
// report dmem_error and have no side effect on the array.

// One byte lane of the backing store; contents deliberately not reset.
module dmem_lane #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] idx,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);
    logic [7:0] mem [DEPTH];

    // byte write on the completion edge
    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
    end

    assign rdata = mem[idx];
endmodule

module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dmem_address,
    input  logic        dmem_enable,
    input  logic [31:0] dmem_write_data,
    input  logic        dmem_write_enable,
    input  logic [2:0]  dmem_write_mode,
    input  logic        dmem_read_enable,
    input  logic [2:0]  dmem_read_mode,
    output logic [31:0] dmem_read_data,
    output logic        dmem_wait,
    output logic        dmem_error
);
    localparam int AW        = $clog2(DEPTH_WORDS);
    localparam int NUM_LANES = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic        re;
        logic [2:0]  wmode;
        logic [2:0]  rmode;
    } req_t;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t state;
    logic [3:0] cnt;
    req_t live, held, cur;
    logic accept, complete;

    assign live = '{addr: dmem_address, wdata: dmem_write_data,
                    we: dmem_write_enable, re: dmem_read_enable,
                    wmode: dmem_write_mode, rmode: dmem_read_mode};

    assign accept = (state == IDLE) && dmem_enable &&
                    (dmem_read_enable || dmem_write_enable);

    // Zero wait states complete straight off the bus; otherwise the latched
    // request is replayed on the last BUSY edge.
    assign cur      = (WAIT_CYCLES == 0) ? live : held;
    assign complete = (WAIT_CYCLES == 0) ? accept
                                         : ((state == BUSY) && (cnt == 4'd1));
    assign dmem_wait = (state == BUSY);

    // Access decode: a store wins when both enables are set.
    logic        is_store, is_load;
    logic [2:0]  mode;
    logic [1:0]  size;
    logic        mode_ok, misaligned, out_of_range, err;
    logic [AW-1:0] idx;

    assign is_store = cur.we;
    assign is_load  = cur.re && !cur.we;
    assign mode     = is_store ? cur.wmode : cur.rmode;
    assign size     = mode[1:0];
    assign idx      = cur.addr[AW+1:2];

    // legality, alignment and range checks
    always_comb begin
        mode_ok = 1'b0;
        if (is_store) mode_ok = mode inside {3'b000, 3'b001, 3'b010};
        else          mode_ok = mode inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        misaligned   = ((size == 2'b01) && cur.addr[0]) ||
                       ((size == 2'b10) && (cur.addr[1:0] != 2'b00));
        out_of_range = ({1'b0, cur.addr} >= (33'(DEPTH_WORDS) << 2));
        err          = !mode_ok || misaligned || out_of_range;
    end

    // Store lane selection: replicate the LSB-aligned data so each lane
    // simply picks its own byte.
    logic [NUM_LANES-1:0]      byte_en, lane_we;
    logic [NUM_LANES-1:0][7:0] lane_wdata, word_rd;

    // byte enables and replicated write data per access size
    always_comb begin
        byte_en    = 4'b0000;
        lane_wdata = cur.wdata;
        case (size)
            2'b00: begin
                byte_en    = 4'b0001 << cur.addr[1:0];
                lane_wdata = {4{cur.wdata[7:0]}};
            end
            2'b01: begin
                byte_en    = cur.addr[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{cur.wdata[15:0]}};
            end
            2'b10:   byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    end

    assign lane_we = (complete && is_store && !err) ? byte_en : 4'b0000;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        dmem_lane #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_lane (
            .clk   (clk),
            .we    (lane_we[i]),
            .idx   (idx),
            .wdata (lane_wdata[i]),
            .rdata (word_rd[i])
        );
    end

    // Load formatting: right-justify the addressed lanes, zero above.
    logic [31:0] rd_shift, load_val;

    // shift and mask the fetched word to the access width
    always_comb begin
        rd_shift = word_rd >> {cur.addr[1:0], 3'b000};
        case (size)
            2'b00:   load_val = {24'h0, rd_shift[7:0]};
            2'b01:   load_val = {16'h0, rd_shift[15:0]};
            default: load_val = rd_shift;
        endcase
    end

    // IDLE/BUSY sequencing plus registered response outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            held           <= '0;
            dmem_read_data <= 32'h0;
            dmem_error     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && (WAIT_CYCLES != 0)) begin
                        held  <= live;
                        cnt   <= 4'(WAIT_CYCLES);
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (complete) begin
                dmem_error <= err;
                if (is_load) dmem_read_data <= err ? 32'h0 : load_val;
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with 0, 2 and 3 wait
// states, each with its own request bundle and reset.
module tb_dmem_responder;
    logic clk;
    logic rst [3];
    logic en [3], we [3], re [3];
    logic [2:0] wm [3], rm [3];
    logic [31:0] ad [3], wd [3];
    logic [31:0] rdat [3];
    logic wt [3], er [3];
    int tests = 0, fails = 0;
    int nw;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES((g == 0) ? 0 : (g == 1) ? 2 : 3)) u_dut (
            .clk               (clk),
            .reset             (rst[g]),
            .dmem_address      (ad[g]),
            .dmem_enable       (en[g]),
            .dmem_write_data   (wd[g]),
            .dmem_write_enable (we[g]),
            .dmem_write_mode   (wm[g]),
            .dmem_read_enable  (re[g]),
            .dmem_read_mode    (rm[g]),
            .dmem_read_data    (rdat[g]),
            .dmem_wait         (wt[g]),
            .dmem_error        (er[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One request; returns how many cycles dmem_wait stayed high after accept.
    task automatic access(input int d, input logic w, input logic r, input logic [2:0] wmd,
                          input logic [2:0] rmd, input logic [31:0] a, input logic [31:0] dat,
                          input bit junk, output int nwait);
        @(negedge clk);
        en[d] = 1'b1; we[d] = w; re[d] = r; wm[d] = wmd; rm[d] = rmd; ad[d] = a; wd[d] = dat;
        @(posedge clk); #1;
        en[d] = 1'b0; we[d] = 1'b0; re[d] = 1'b0;
        if (junk) begin
            en[d] = 1'b1; we[d] = 1'b1; wm[d] = 3'b010; ad[d] = 32'h10; wd[d] = 32'h0;
        end
        nwait = 0;
        while (wt[d] && nwait < 20) begin
            @(posedge clk); #1;
            nwait++;
        end
        en[d] = 1'b0; we[d] = 1'b0;
    endtask

    task automatic test_reset;
        for (int d = 0; d < 3; d++) begin
            tests++; if (wt[d] !== 1'b0 || er[d] !== 1'b0 || rdat[d] !== 32'h0) begin
                fails++; $display("FAIL reset_dut%0d: wait=%b err=%b rd=%h want 0/0/0", d, wt[d], er[d], rdat[d]); end
        end
    endtask

    task automatic test_word_basic;
        access(0, 1, 0, 3'b010, 3'b000, 32'h10, 32'hDEADBEEF, 0, nw);
        tests++; if (er[0] !== 1'b0 || nw !== 0 || wt[0] !== 1'b0) begin
            fails++; $display("FAIL sw_basic: err=%b nwait=%0d wait=%b want 0/0/0", er[0], nw, wt[0]); end
        access(0, 0, 1, 3'b000, 3'b010, 32'h10, 32'h0, 0, nw);
        tests++; if (rdat[0] !== 32'hDEADBEEF || er[0] !== 1'b0 || nw !== 0) begin
            fails++; $display("FAIL lw_basic: rd=%h err=%b nwait=%0d want deadbeef/0/0", rdat[0], er[0], nw); end
    endtask

    task automatic test_sub_word;
        access(0, 1, 0, 3'b000, 3'b000, 32'h13, 32'h000000A5, 0, nw);
        access(0, 0, 1, 3'b000, 3'b010, 32'h10, 32'h0, 0, nw);
        tests++; if (rdat[0] !== 32'hA5ADBEEF) begin
            fails++; $display("FAIL lw_after_sb: got %h want a5adbeef", rdat[0]); end
        access(0, 0, 1, 3'b000, 3'b100, 32'h13, 32'h0, 0, nw);
        tests++; if (rdat[0] !== 32'h000000A5) begin
            fails++; $display("FAIL lbu_13: got %h want 000000a5", rdat[0]); end
        access(0, 0, 1, 3'b000, 3'b001, 32'h12, 32'h0, 0, nw);
        tests++; if (rdat[0] !== 32'h0000A5AD) begin
            fails++; $display("FAIL lh_12: got %h want 0000a5ad", rdat[0]); end
        access(0, 0, 1, 3'b000, 3'b000, 32'h11, 32'h0, 0, nw);
        tests++; if (rdat[0] !== 32'h000000BE) begin
            fails++; $display("FAIL lb_11: got %h want 000000be", rdat[0]); end
        access(0, 0, 1, 3'b000, 3'b101, 32'h10, 32'h0, 0, nw);
        tests++; if (rdat[0] !== 32'h0000BEEF) begin
            fails++; $display("FAIL lhu_10: got %h want 0000beef", rdat[0]); end
        access(0, 1, 0, 3'b001, 3'b000, 32'h12, 32'hFFFF1234, 0, nw);
        access(0, 0, 1, 3'b000, 3'b010, 32'h10, 32'h0, 0, nw);
        tests++; if (rdat[0] !== 32'h1234BEEF || er[0] !== 1'b0) begin
            fails++; $display("FAIL lw_after_sh: rd=%h err=%b want 1234beef/0", rdat[0], er[0]); end
    endtask

    task automatic test_errors;
        access(0, 1, 0, 3'b001, 3'b000, 32'h11, 32'h00001234, 0, nw);
        tests++; if (er[0] !== 1'b1 || rdat[0] !== 32'h1234BEEF) begin
            fails++; $display("FAIL sh_misaligned: err=%b rd=%h want 1/1234beef", er[0], rdat[0]); end
        access(0, 1, 0, 3'b011, 3'b000, 32'h10, 32'h0, 0, nw);
        tests++; if (er[0] !== 1'b1) begin
            fails++; $display("FAIL bad_wmode: err=%b want 1", er[0]); end
        access(0, 0, 1, 3'b000, 3'b010, 32'h10, 32'h0, 0, nw);
        tests++; if (rdat[0] !== 32'h1234BEEF || er[0] !== 1'b0) begin
            fails++; $display("FAIL store_suppressed: rd=%h err=%b want 1234beef/0", rdat[0], er[0]); end
        access(0, 0, 1, 3'b000, 3'b110, 32'h10, 32'h0, 0, nw);
        tests++; if (rdat[0] !== 32'h0 || er[0] !== 1'b1) begin
            fails++; $display("FAIL bad_rmode: rd=%h err=%b want 0/1", rdat[0], er[0]); end
        access(0, 0, 1, 3'b000, 3'b010, 32'h10, 32'h0, 0, nw);
        access(0, 0, 1, 3'b000, 3'b010, 32'h4000, 32'h0, 0, nw);
        tests++; if (rdat[0] !== 32'h0 || er[0] !== 1'b1) begin
            fails++; $display("FAIL lw_4000: rd=%h err=%b want 0/1", rdat[0], er[0]); end
        access(0, 0, 1, 3'b000, 3'b010, 32'h12, 32'h0, 0, nw);
        tests++; if (rdat[0] !== 32'h0 || er[0] !== 1'b1) begin
            fails++; $display("FAIL lw_misaligned: rd=%h err=%b want 0/1", rdat[0], er[0]); end
        access(0, 1, 0, 3'b010, 3'b000, 32'hFFC, 32'h0BADF00D, 0, nw);
        access(0, 0, 1, 3'b000, 3'b010, 32'hFFC, 32'h0, 0, nw);
        tests++; if (rdat[0] !== 32'h0BADF00D || er[0] !== 1'b0) begin
            fails++; $display("FAIL lw_last_word: rd=%h err=%b want 0badf00d/0", rdat[0], er[0]); end
        access(0, 0, 1, 3'b000, 3'b100, 32'hFFF, 32'h0, 0, nw);
        tests++; if (rdat[0] !== 32'h0000000B || er[0] !== 1'b0) begin
            fails++; $display("FAIL lbu_last_byte: rd=%h err=%b want 0000000b/0", rdat[0], er[0]); end
        access(0, 0, 1, 3'b000, 3'b000, 32'h1000, 32'h0, 0, nw);
        tests++; if (rdat[0] !== 32'h0 || er[0] !== 1'b1) begin
            fails++; $display("FAIL lb_1000: rd=%h err=%b want 0/1", rdat[0], er[0]); end
    endtask

    task automatic test_both_enables;
        access(0, 0, 1, 3'b000, 3'b010, 32'h10, 32'h0, 0, nw);
        access(0, 1, 1, 3'b010, 3'b010, 32'h14, 32'h11223344, 0, nw);
        tests++; if (rdat[0] !== 32'h1234BEEF || er[0] !== 1'b0) begin
            fails++; $display("FAIL both_en_rd_held: rd=%h err=%b want 1234beef/0", rdat[0], er[0]); end
        access(0, 0, 1, 3'b000, 3'b010, 32'h14, 32'h0, 0, nw);
        tests++; if (rdat[0] !== 32'h11223344) begin
            fails++; $display("FAIL both_en_stored: got %h want 11223344", rdat[0]); end
    endtask

    task automatic test_wait_states;
        access(1, 1, 0, 3'b010, 3'b000, 32'h10, 32'hCAFEF00D, 0, nw);
        tests++; if (nw !== 2 || er[1] !== 1'b0) begin
            fails++; $display("FAIL w2_sw: nwait=%0d err=%b want 2/0", nw, er[1]); end
        access(1, 0, 1, 3'b000, 3'b010, 32'h10, 32'h0, 1, nw);
        tests++; if (nw !== 2 || rdat[1] !== 32'hCAFEF00D) begin
            fails++; $display("FAIL w2_lw_junk: nwait=%0d rd=%h want 2/cafef00d", nw, rdat[1]); end
        access(1, 0, 1, 3'b000, 3'b010, 32'h10, 32'h0, 0, nw);
        tests++; if (rdat[1] !== 32'hCAFEF00D) begin
            fails++; $display("FAIL w2_junk_ignored: got %h want cafef00d", rdat[1]); end
        access(1, 1, 0, 3'b001, 3'b000, 32'h11, 32'h1234, 0, nw);
        tests++; if (nw !== 2 || er[1] !== 1'b1 || rdat[1] !== 32'hCAFEF00D) begin
            fails++; $display("FAIL w2_sh_err: nwait=%0d err=%b rd=%h want 2/1/cafef00d", nw, er[1], rdat[1]); end
        access(1, 0, 1, 3'b000, 3'b010, 32'h10, 32'h0, 0, nw);
        tests++; if (rdat[1] !== 32'hCAFEF00D || er[1] !== 1'b0) begin
            fails++; $display("FAIL w2_word_unchanged: rd=%h err=%b want cafef00d/0", rdat[1], er[1]); end
    endtask

    task automatic test_reset_abort;
        access(2, 1, 0, 3'b010, 3'b000, 32'h20, 32'h11111111, 0, nw);
        tests++; if (nw !== 3) begin
            fails++; $display("FAIL w3_sw: nwait=%0d want 3", nw); end
        access(2, 0, 1, 3'b000, 3'b010, 32'h20, 32'h0, 0, nw);
        access(2, 1, 0, 3'b001, 3'b000, 32'h21, 32'h0, 0, nw);
        tests++; if (rdat[2] !== 32'h11111111 || er[2] !== 1'b1) begin
            fails++; $display("FAIL w3_pre_abort: rd=%h err=%b want 11111111/1", rdat[2], er[2]); end
        @(negedge clk);
        en[2] = 1'b1; we[2] = 1'b1; wm[2] = 3'b010; ad[2] = 32'h20; wd[2] = 32'h55;
        @(posedge clk); #1;
        en[2] = 1'b0; we[2] = 1'b0;
        tests++; if (wt[2] !== 1'b1) begin
            fails++; $display("FAIL w3_busy: wait=%b want 1", wt[2]); end
        @(posedge clk); #3;
        rst[2] = 1'b1;
        #1;
        tests++; if (wt[2] !== 1'b0 || rdat[2] !== 32'h0 || er[2] !== 1'b0) begin
            fails++; $display("FAIL async_abort: wait=%b rd=%h err=%b want 0/0/0", wt[2], rdat[2], er[2]); end
        @(negedge clk);
        rst[2] = 1'b0;
        access(2, 0, 1, 3'b000, 3'b010, 32'h20, 32'h0, 0, nw);
        tests++; if (rdat[2] !== 32'h11111111 || nw !== 3 || er[2] !== 1'b0) begin
            fails++; $display("FAIL store_aborted: rd=%h nwait=%0d err=%b want 11111111/3/0", rdat[2], nw, er[2]); end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; en[d] = 1'b0; we[d] = 1'b0; re[d] = 1'b0;
            wm[d] = 3'b000; rm[d] = 3'b000; ad[d] = 32'h0; wd[d] = 32'h0;
        end
        #2;
        test_reset;
        @(negedge clk);
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;
        test_word_basic;
        test_sub_word;
        test_errors;
        test_both_enables;
        test_wait_states;
        test_reset_abort;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, 1024, number of 32-bit words backed (power of two).
REQ-002 SHALL have parameter WAIT_CYCLES, 0, stall cycles inserted per accepted access (0-15).
REQ-003 SHALL have one clock and an asynchronous, active-high reset; ports `clk` and `reset`.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 dmem_address  input  32  byte address of request.
REQ-007 dmem_enable  input  1  request strobe; sampled only in IDLE.
REQ-008 dmem_write_data  input  32  store data, LSB-aligned.
REQ-009 dmem_write_enable  input  1  store request.
REQ-010 dmem_write_mode  input  3  000 byte, 001 half, 010 word.
REQ-011 dmem_read_enable  input  1  load request.
REQ-012 dmem_read_mode  input  3  000/100 byte, 001/101 half, 010 word.
REQ-013 dmem_read_data  output  32  loaded lanes shifted to bit 0, upper bits zero.
REQ-014 dmem_wait  output  1  high while an access is in progress.
REQ-015 dmem_error  output  1  last completed access misaligned, out of range or illegal mode.

Function
REQ-016 Accept: rising edge with state IDLE, dmem_enable=1, and dmem_read_enable or dmem_write_enable =1; otherwise no action.
REQ-017 Both enables high: treated as store only; dmem_read_data unchanged.
REQ-018 States IDLE, BUSY; dmem_wait = (state==BUSY), combinational from state only.
REQ-019 WAIT_CYCLES=0: access completes on the accept edge; state stays IDLE; dmem_wait never asserts.
REQ-020 WAIT_CYCLES=N>0: accept edge latches address, data, modes, enables; loads counter N; enters BUSY.
REQ-021 BUSY: counter decrements each edge; on the edge where counter==1 the access completes and state returns to IDLE; dmem_wait high exactly N cycles.
REQ-022 dmem_enable and all request inputs ignored while BUSY.
REQ-023 Completion of load: dmem_read_data <= selected lanes >> (8*address[1:0]), zero-filled above width; held until next completed load.
REQ-024 Completion of store: byte writes lane address[1:0] with write_data[7:0]; half writes lanes address[1]*2+{0,1} with write_data[15:0]; word writes all lanes; other lanes untouched.
REQ-025 Word index = address[log2(DEPTH_WORDS)+1:2]; address >= 4*DEPTH_WORDS is out of range.
REQ-026 Error: half with address[0]=1, word with address[1:0]!=0, out of range, or mode not listed in REQ-010/012.
REQ-027 On error: store suppressed, load returns 0, dmem_error=1; otherwise dmem_error=0; updated at every completion, held between.
REQ-028 Read modes 100/101 fetch identically to 000/001; extension is the requester's job.
REQ-029 Same-address store followed by load on next accepted request returns the stored value (no read-before-write hazard).

Reset
REQ-030 reset=1 forces state IDLE, counter 0, dmem_wait=0, dmem_read_data=0, dmem_error=0 immediately, without waiting for clk.
REQ-031 reset during BUSY aborts the access; a pending store is not performed.
REQ-032 Memory array contents are not cleared by reset.

Verification
REQ-033 WAIT_CYCLES=0: sw 0xDEADBEEF @0x10, then lw @0x10 -> dmem_read_data=0xDEADBEEF one edge later, dmem_wait constant 0, dmem_error=0.
REQ-034 After REQ-033: sb data 0x000000A5 @0x13, lw @0x10 -> 0xA5ADBEEF; lbu @0x13 -> 0x000000A5; lh @0x12 -> 0x0000A5AD.
REQ-035 WAIT_CYCLES=2: lw @0x10 -> dmem_wait high exactly 2 cycles after accept; data valid when dmem_wait falls; enable pulses during BUSY ignored.
REQ-036 sh @0x11 data 0x1234 -> dmem_error=1, word @0x10 unchanged; lw @0x4000 with DEPTH_WORDS=1024 -> read_data 0, dmem_error=1.
REQ-037 WAIT_CYCLES=3: sw 0x55 @0x20, assert reset in second BUSY cycle -> dmem_wait, dmem_read_data, dmem_error drop to 0 asynchronously; later lw @0x20 returns prior contents.
